// File: rtl/ua_seq_if.sv
// Bus bundle between a microprogram sequencer and its host/datapath.
// The master side loads the program and starts runs; the slave side is the sequencer.
interface ua_seq_if #(
    parameter int P_W    = 9,
    parameter int Y_W    = 12,
    parameter int ADDR_W = 5
);
    localparam int CS_W = (P_W > 1) ? $clog2(P_W) : 1;
    localparam int UW   = Y_W + CS_W + 1 + 2 + ADDR_W;

    logic [P_W-1:0]    p;
    logic              start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [UW-1:0]     wr_data;
    logic [Y_W-1:0]    y;
    logic              clkout;
    logic              Z;
    logic              busy;
    logic              err;

    modport master (
        output p, start, wr_en, wr_addr, wr_data,
        input  y, clkout, Z, busy, err
    );

    modport slave (
        input  p, start, wr_en, wr_addr, wr_data,
        output y, clkout, Z, busy, err
    );
endinterface

// File: rtl/ua_seq.sv
// Microprogrammed control sequencer: fetches words from a writable control store,
// issues their control field each cycle and follows CONT/JUMP/BRANCH/END sequencing.
module ua_seq #(
    parameter int P_W        = 9,
    parameter int Y_W        = 12,
    parameter int ADDR_W     = 5,
    parameter int START_ADDR = 0,
    parameter int MAX_STEPS  = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    ua_seq_if.slave bus
);
    localparam int CS_W   = (P_W > 1) ? $clog2(P_W) : 1;
    localparam int UW     = Y_W + CS_W + 1 + 2 + ADDR_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PAD_W  = 2 ** CS_W;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [1:0] TYP_JUMP   = 2'b01;
    localparam logic [1:0] TYP_BRANCH = 2'b10;
    localparam logic [1:0] TYP_END    = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [UW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] pc;
    logic [STEP_W-1:0] steps;
    logic [Y_W-1:0]    yReg;
    logic              zReg;
    logic              errReg;

    logic [UW-1:0]     word;
    logic [Y_W-1:0]    wordY;
    logic [CS_W-1:0]   wordCs;
    logic              wordPol;
    logic [1:0]        wordTyp;
    logic [ADDR_W-1:0] wordAddr;
    logic [PAD_W-1:0]  pPad;
    logic              cond;
    logic [ADDR_W-1:0] nextPc;

    assign word = mem[pc];
    assign {wordY, wordCs, wordPol, wordTyp, wordAddr} = word;

    // Zero-padding p makes condition selects beyond P_W read as 0.
    assign pPad = PAD_W'(bus.p);
    assign cond = pPad[wordCs];

    always_comb begin
        nextPc = pc + ADDR_W'(1);
        case (wordTyp)
            TYP_JUMP:   nextPc = wordAddr;
            TYP_BRANCH: if (cond == wordPol) nextPc = wordAddr;
            default:    nextPc = pc + ADDR_W'(1);
        endcase
    end

    // Control store survives reset and is frozen while a program runs.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state != RUN) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= '0;
            steps  <= '0;
            yReg   <= '0;
            zReg   <= 1'b0;
            errReg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    yReg <= '0;
                    if (bus.start) begin
                        state  <= RUN;
                        pc     <= ADDR_W'(START_ADDR);
                        steps  <= '0;
                        zReg   <= 1'b0;
                        errReg <= 1'b0;
                    end
                end
                RUN: begin
                    // END is tested first so it beats a simultaneous watchdog expiry.
                    if (wordTyp == TYP_END) begin
                        yReg  <= wordY;
                        zReg  <= 1'b1;
                        state <= DONE;
                    end else if (steps == STEP_W'(MAX_STEPS)) begin
                        yReg   <= '0;
                        zReg   <= 1'b1;
                        errReg <= 1'b1;
                        state  <= DONE;
                    end else begin
                        yReg  <= wordY;
                        pc    <= nextPc;
                        steps <= steps + STEP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y      = yReg;
    assign bus.Z      = zReg;
    assign bus.err    = errReg;
    assign bus.busy   = (state == RUN);
    assign bus.clkout = ~clk;
endmodule

// File: tb/tb_ua_seq.sv
// Self-checking bench for ua_seq: a trace-level reference model walks the loaded program
// and a per-cycle compare process checks y/Z/err/busy/clkout against it.
module tb_ua_seq;
    localparam int P_W       = 9;
    localparam int Y_W       = 12;
    localparam int ADDR_W    = 5;
    localparam int MAX_STEPS = 64;
    localparam int CS_W      = 4;
    localparam int UW        = Y_W + CS_W + 1 + 2 + ADDR_W;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ua_seq_if #(.P_W(P_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus ();
    ua_seq_if #(.P_W(P_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus2 ();

    ua_seq #(.P_W(P_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .START_ADDR(0), .MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    ua_seq #(.P_W(P_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .START_ADDR(31), .MAX_STEPS(MAX_STEPS)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;

    logic [UW-1:0]  modelMem [DEPTH];
    logic [P_W-1:0] pSeq [MAX_STEPS+2];
    logic [Y_W-1:0] trY [MAX_STEPS+1];
    int             trLen;
    logic           trErr;

    logic           checkEn = 1'b0;
    logic [Y_W-1:0] expY    = '0;
    logic           expZ    = 1'b0;
    logic           expErr  = 1'b0;
    logic           expBusy = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [UW-1:0] makeWord(input logic [Y_W-1:0] yf, input logic [CS_W-1:0] cs,
                                               input logic pol, input logic [1:0] typ,
                                               input logic [ADDR_W-1:0] addr);
        return {yf, cs, pol, typ, addr};
    endfunction

    // Walk the program as the microinstruction rules dictate, producing the y value
    // issued on each run cycle; the last entry is the cycle that ends the run.
    function automatic void buildTrace(input int startAddr);
        int             pc;
        int             cs;
        logic [UW-1:0]  w;
        logic [Y_W-1:0] yf;
        logic           pol;
        logic [1:0]     typ;
        logic [ADDR_W-1:0] tgt;
        logic           cond;
        pc    = startAddr;
        trErr = 1'b0;
        trLen = 0;
        for (int n = 0; n <= MAX_STEPS; n++) begin
            w     = modelMem[pc];
            yf    = w[UW-1 -: Y_W];
            cs    = int'(w[ADDR_W+3 +: CS_W]);
            pol   = w[ADDR_W+2];
            typ   = w[ADDR_W +: 2];
            tgt   = w[ADDR_W-1:0];
            trLen = n + 1;
            if (typ == 2'b11) begin
                trY[n] = yf;
                break;
            end
            if (n == MAX_STEPS) begin
                trY[n] = '0;
                trErr  = 1'b1;
                break;
            end
            trY[n] = yf;
            cond   = (cs < P_W) ? pSeq[n][cs] : 1'b0;
            case (typ)
                2'b01:   pc = int'(tgt);
                2'b10:   pc = (cond == pol) ? int'(tgt) : (pc + 1) % DEPTH;
                default: pc = (pc + 1) % DEPTH;
            endcase
        end
    endfunction

    always @(negedge clk) begin
        #1;
        if (checkEn) begin
            checkOutput("y", 32'(bus.y), 32'(expY));
            checkOutput("Z", 32'(bus.Z), 32'(expZ));
            checkOutput("err", 32'(bus.err), 32'(expErr));
            checkOutput("busy", 32'(bus.busy), 32'(expBusy));
            checkOutput("clkout", 32'(bus.clkout), 32'd1);
        end
    end

    task automatic writeWord(input logic [ADDR_W-1:0] addr, input logic [UW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        modelMem[addr] = data;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // pMode 0: fully random p; pMode 1: p[8] low for four cycles, then high.
    // wrNoise drives random writes near the executing addresses while running.
    task automatic applyStimulus(input int pMode, input bit wrNoise);
        for (int i = 0; i < MAX_STEPS + 2; i++) begin
            pSeq[i] = P_W'($urandom);
            if (pMode == 1) pSeq[i][8] = (i >= 4);
        end
        buildTrace(0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        expY = '0; expZ = 1'b0; expErr = 1'b0; expBusy = 1'b1;
        bus.start = 1'b0;
        bus.p     = pSeq[0];
        bus.wr_en = wrNoise && (trLen > 1);
        bus.wr_addr = ADDR_W'($urandom_range(0, 3));
        bus.wr_data = UW'($urandom);
        for (int k = 0; k < trLen; k++) begin
            @(posedge clk); #1;
            expY    = trY[k];
            expZ    = (k == trLen - 1);
            expErr  = (k == trLen - 1) && trErr;
            expBusy = (k != trLen - 1);
            bus.p   = pSeq[k+1];
            bus.wr_en   = wrNoise && (k < trLen - 2);
            bus.wr_addr = ADDR_W'($urandom_range(0, 3));
            bus.wr_data = UW'($urandom);
        end
        @(posedge clk); #1;
        expY    = '0;
        expBusy = 1'b0;
    endtask

    task automatic pinBasicProgram(input string tag);
        checkOutput({tag, "_len"}, 32'(trLen), 32'd3);
        checkOutput({tag, "_y0"}, 32'(trY[0]), 32'h412);
        checkOutput({tag, "_y1"}, 32'(trY[1]), 32'h104);
        checkOutput({tag, "_y2"}, 32'(trY[2]), 32'h002);
        checkOutput({tag, "_err"}, 32'(trErr), 32'd0);
    endtask

    initial begin
        bus.p = '0; bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus2.p = '0; bus2.start = 1'b0; bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_y", 32'(bus.y), 32'd0);
        checkOutput("reset_Z", 32'(bus.Z), 32'd0);
        checkOutput("reset_err", 32'(bus.err), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        rst_n   = 1'b1;
        checkEn = 1'b1;
        idleCycles(2);

        // Straight-line program ending in END.
        writeWord(5'd0, makeWord(12'h412, 4'd0, 1'b0, 2'b00, 5'd0));
        writeWord(5'd1, makeWord(12'h104, 4'd0, 1'b0, 2'b00, 5'd0));
        writeWord(5'd2, makeWord(12'h002, 4'd0, 1'b0, 2'b11, 5'd0));
        applyStimulus(0, 1'b0);
        pinBasicProgram("basic");
        idleCycles(2);

        // Same program with write attempts during RUN; output must be unchanged.
        applyStimulus(0, 1'b1);
        pinBasicProgram("runwrite");
        idleCycles(1);

        // Wait-on-condition: branch to self while p[8] is low.
        writeWord(5'd0, makeWord(12'h002, 4'd8, 1'b0, 2'b10, 5'd0));
        writeWord(5'd1, makeWord(12'h800, 4'd0, 1'b0, 2'b11, 5'd0));
        applyStimulus(1, 1'b0);
        checkOutput("wait_len", 32'(trLen), 32'd6);
        checkOutput("wait_y4", 32'(trY[4]), 32'h002);
        checkOutput("wait_y5", 32'(trY[5]), 32'h800);
        idleCycles(1);

        // Self-jump loop trips the watchdog.
        writeWord(5'd0, makeWord(12'h001, 4'd0, 1'b0, 2'b01, 5'd0));
        applyStimulus(0, 1'b0);
        checkOutput("wdog_len", 32'(trLen), 32'd65);
        checkOutput("wdog_y63", 32'(trY[63]), 32'h001);
        checkOutput("wdog_y64", 32'(trY[64]), 32'h000);
        checkOutput("wdog_err", 32'(trErr), 32'd1);
        idleCycles(1);

        // Asynchronous reset three steps into a run, then a clean rerun.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        expY = '0; expZ = 1'b0; expErr = 1'b0; expBusy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            expY = 12'h001;
        end
        #2 rst_n = 1'b0;
        expY = '0; expZ = 1'b0; expErr = 1'b0; expBusy = 1'b0;
        #1;
        checkOutput("async_y", 32'(bus.y), 32'd0);
        checkOutput("async_Z", 32'(bus.Z), 32'd0);
        checkOutput("async_busy", 32'(bus.busy), 32'd0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(3);
        applyStimulus(0, 1'b0);
        checkOutput("rerun_len", 32'(trLen), 32'd65);
        idleCycles(1);

        // Address wrap on the START_ADDR=31 instance.
        bus2.wr_en = 1'b1; bus2.wr_addr = 5'd31;
        bus2.wr_data = makeWord(12'h040, 4'd0, 1'b0, 2'b00, 5'd0);
        @(posedge clk); #1;
        bus2.wr_addr = 5'd0;
        bus2.wr_data = makeWord(12'h020, 4'd0, 1'b0, 2'b11, 5'd0);
        @(posedge clk); #1;
        bus2.wr_en = 1'b0; bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        checkOutput("wrap_busy0", 32'(bus2.busy), 32'd1);
        @(posedge clk); #1;
        checkOutput("wrap_y0", 32'(bus2.y), 32'h040);
        @(posedge clk); #1;
        checkOutput("wrap_y1", 32'(bus2.y), 32'h020);
        checkOutput("wrap_Z1", 32'(bus2.Z), 32'd1);
        @(posedge clk); #1;
        checkOutput("wrap_y2", 32'(bus2.y), 32'h000);
        checkOutput("wrap_busy2", 32'(bus2.busy), 32'd0);

        // Random programs and random condition inputs.
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                writeWord(ADDR_W'(a), makeWord(Y_W'($urandom), CS_W'($urandom_range(0, 15)),
                                               1'($urandom), 2'($urandom_range(0, 3)),
                                               ADDR_W'($urandom)));
            end
            applyStimulus(0, (r % 3) == 0);
            idleCycles(1);
        end

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
